// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch front end.
package rv_fetch_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    localparam logic [31:0] INSN_NOP   = 32'h0000_0013;
    localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-2 depth, extra pointer MSB distinguishes full from empty,
// synchronous flush, head presented combinationally and zeroed while empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // The fetch credit scheme must make this impossible.
    assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction-fetch front end: PC, credit-limited pipelined imem requests, prefetch FIFO,
// redirect/trap flush and EBREAK halt. Define FETCH_MISALIGN_CHK_EN to trap misaligned redirects.
module rv_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted,
    output logic            fetch_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t      state_reg;
    fetch_state_t      state_next;
    logic              started_reg;
    logic              run_en;
    logic [XLEN-1:0]   req_pc_reg;
    logic [XLEN-1:0]   rsp_pc_reg;
    logic [XLEN-1:0]   target;
    logic [CW-1:0]     outstanding_reg;
    logic [CW-1:0]     drop_cnt_reg;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [2*XLEN-1:0] fifo_rdata;
    logic              flush;
    logic              credit_ok;
    logic              fire;
    logic              push;
    logic              pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= RUN;
        else      state_reg <= state_next;
    end

    // halt_req has priority over resume; redirects never change the state.
    always_comb begin
        state_next = state_reg;
        if (halt_req)                          state_next = HALTED;
        else if (state_reg == HALTED && resume) state_next = RUN;
    end

    always_comb begin
        halted = (state_reg == HALTED);
        run_en = started_reg && (state_reg == RUN);
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic fault_next;
    logic fault_reg;

    always_comb begin
        fault_next = 1'b0;
        if (trap_valid) begin
            target = TRAP_VEC;
        end else if (redirect_pc[1:0] != 2'b00) begin
            target     = TRAP_VEC;
            fault_next = redirect_valid;
        end else begin
            target = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fault_reg <= 1'b0;
        else      fault_reg <= fault_next;
    end

    assign fetch_fault = fault_reg;
`else
    always_comb begin
        if (trap_valid) target = TRAP_VEC;
        else            target = redirect_pc & ~XLEN'(3);
    end

    assign fetch_fault = 1'b0;
`endif

    assign flush     = redirect_valid || trap_valid;
    // Buffered plus in-flight (including responses still to be dropped) never exceeds DEPTH.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_reg}) < (CW+1)'(DEPTH);

    assign imem_req_valid = run_en && credit_ok && !flush;
    assign imem_req_addr  = req_pc_reg;
    assign fire           = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && !flush && (drop_cnt_reg == '0);
    assign inst_valid     = !fifo_empty;
    assign pop            = inst_valid && inst_ready && !flush;
    assign inst_pc        = fifo_rdata[2*XLEN-1:XLEN];
    assign inst_data      = fifo_rdata[XLEN-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started_reg     <= 1'b0;
            req_pc_reg      <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            started_reg     <= 1'b1;
            outstanding_reg <= outstanding_reg + CW'(fire) - CW'(imem_rsp_valid);
            if (flush) begin
                req_pc_reg   <= target;
                rsp_pc_reg   <= target;
                // Everything still in flight belongs to the abandoned path.
                drop_cnt_reg <= outstanding_reg - CW'(imem_rsp_valid);
            end else begin
                if (fire) req_pc_reg <= req_pc_reg + XLEN'(WORD_BYTES);
                if (push) rsp_pc_reg <= rsp_pc_reg + XLEN'(WORD_BYTES);
                if (imem_rsp_valid && drop_cnt_reg != '0) drop_cnt_reg <= drop_cnt_reg - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .WIDTH(2*XLEN),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata ({rsp_pc_reg, imem_rsp_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Randomised bench for rv_fetch_unit: in-order variable-latency memory, scoreboard of the
// expected instruction stream, and a cycle-level model of credits, halt and redirects.
`timescale 1ns/1ps
module tb_rv_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid, halt_req, resume, halted, fetch_fault;

    rv_fetch_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .halt_req(halt_req), .resume(resume),
        .halted(halted), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_pop = 0;
    int n_fire = 0;
    int n_flush = 0;

    // Scoreboard: fetched-but-not-consumed stream on the current path, oldest first.
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_data_q[$];
    // Memory model: outstanding requests in order, with the cycle each may respond.
    int          pend_due[$];
    logic [31:0] pend_pc[$];
    int          stale_cnt = 0;
    logic        started = 1'b0;
    logic        m_halted = 1'b0;
    logic        exp_fault = 1'b0;
    logic [31:0] m_req_pc = RESET_PC;

    int unsigned p_ready = 100, p_iready = 100, p_redir = 0, p_trap = 0, p_halt = 0, p_resume = 0;
    int unsigned max_lat = 1;
    bit          hold_rsp = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: samples 1 ns before each rising edge.
    logic        mflush, fire_m, pop_m, exp_valid;
    int          buffered;
    logic [31:0] tgt;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                check("reset_req_valid", 32'(imem_req_valid), 32'd0);
                check("reset_req_addr", imem_req_addr, RESET_PC);
                check("reset_inst_valid", 32'(inst_valid), 32'd0);
                check("reset_inst_pc", inst_pc, 32'd0);
                check("reset_inst_data", inst_data, 32'd0);
                check("reset_halted", 32'(halted), 32'd0);
                check("reset_fetch_fault", 32'(fetch_fault), 32'd0);
            end else begin
                mflush    = redirect_valid || trap_valid;
                buffered  = exp_pc_q.size() - (pend_due.size() - stale_cnt);
                exp_valid = started && !m_halted && !mflush &&
                            (exp_pc_q.size() + stale_cnt < DEPTH);
                fire_m    = exp_valid && imem_req_ready;
                pop_m     = (buffered > 0) && inst_ready && !mflush;

                check("req_valid", 32'(imem_req_valid), 32'(exp_valid));
                check("halted", 32'(halted), 32'(m_halted));
                check("inst_valid", 32'(inst_valid), 32'(buffered > 0));
                check("fetch_fault", 32'(fetch_fault), 32'(exp_fault));
                if (fire_m) check("req_addr", imem_req_addr, m_req_pc);
                if (pop_m) begin
                    check("inst_pc", inst_pc, exp_pc_q[0]);
                    check("inst_data", inst_data, exp_data_q[0]);
                end

                exp_fault = 1'b0;
                if (imem_rsp_valid) begin
                    void'(pend_due.pop_front());
                    void'(pend_pc.pop_front());
                end
                if (mflush) begin
                    if (trap_valid) tgt = TRAP_VEC;
`ifdef FETCH_MISALIGN_CHK_EN
                    else if (redirect_pc % 4 != 0) begin
                        tgt       = TRAP_VEC;
                        exp_fault = 1'b1;
                    end
`endif
                    else tgt = redirect_pc - (redirect_pc % 4);
                    exp_pc_q.delete();
                    exp_data_q.delete();
                    stale_cnt = pend_due.size();
                    m_req_pc  = tgt;
                    n_flush++;
                end else begin
                    if (imem_rsp_valid && stale_cnt > 0) stale_cnt--;
                    if (pop_m) begin
                        void'(exp_pc_q.pop_front());
                        void'(exp_data_q.pop_front());
                        n_pop++;
                    end
                    if (fire_m) begin
                        pend_due.push_back(cyc + int'($urandom_range(max_lat, 1)));
                        pend_pc.push_back(m_req_pc);
                        exp_pc_q.push_back(m_req_pc);
                        exp_data_q.push_back(mem_word(m_req_pc));
                        m_req_pc = m_req_pc + 32'd4;
                        n_fire++;
                    end
                end
                if (halt_req)    m_halted = 1'b1;
                else if (resume) m_halted = 1'b0;
                started = 1'b1;
            end
            cyc++;
        end
    end

    function automatic logic [31:0] pick_target();
        case ($urandom_range(5))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0040;
            2:       return 32'h0000_0102;
            3:       return 32'hFFFF_FFF0;
            4:       return 32'hFFFF_FFF3;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive();
        imem_req_ready = ($urandom_range(99) < p_ready);
        inst_ready     = ($urandom_range(99) < p_iready);
        if (!hold_rsp && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_pc[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        redirect_valid = ($urandom_range(99) < p_redir);
        redirect_pc    = pick_target();
        trap_valid     = ($urandom_range(99) < p_trap);
        halt_req       = ($urandom_range(99) < p_halt);
        resume         = ($urandom_range(99) < p_resume);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive();
        end
    endtask

    task automatic one_redirect(input logic [31:0] pc, input logic trap);
        @(negedge clk);
        drive();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        trap_valid     = trap;
        halt_req       = 1'b0;
    endtask

    initial begin
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        trap_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drive();
        // Streaming with a 1-cycle memory and an always-ready decoder.
        run(20);
        // Memory stalls: credits run out after DEPTH requests.
        hold_rsp = 1'b1; p_iready = 0;
        run(12);
        hold_rsp = 1'b0;
        run(2);
        one_redirect(32'h0000_0100, 1'b0);
        p_iready = 100;
        run(12);
        one_redirect(32'h0000_0040, 1'b1);
        run(8);
        one_redirect(32'h0000_0102, 1'b0);
        run(8);
        one_redirect(32'hFFFF_FFF8, 1'b0);
        run(8);
        // Halt with entries buffered, drain, then resume.
        p_iready = 0; run(6);
        @(negedge clk); drive(); halt_req = 1'b1;
        p_iready = 100; run(10);
        @(negedge clk); drive(); resume = 1'b1; halt_req = 1'b0;
        run(10);
        // Fully random traffic.
        p_ready = 70; p_iready = 60; max_lat = 4;
        p_redir = 4; p_trap = 2; p_halt = 2; p_resume = 15;
        run(2000);
        p_redir = 0; p_trap = 0; p_halt = 0; p_resume = 100;
        run(40);
        @(negedge clk);
        check("deliveries_made", 32'(n_pop > 300), 32'd1);
        check("flushes_made", 32'(n_flush > 20), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
